// File: rtl/regfile_wr_arbiter_if.sv
// Write-port request/grant bundle between three producers and the register
// bank write arbiter.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] reqDr;
  logic [NREQ*DW-1:0] reqData;
  logic [NREQ-1:0]    gnt;
  logic               write;
  logic [AW-1:0]      dr;
  logic [DW-1:0]      wrData;
  logic               busy;

  modport master (
    output req, reqDr, reqData,
    input  gnt, write, dr, wrData, busy
  );

  modport slave (
    input  req, reqDr, reqData,
    output gnt, write, dr, wrData, busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Three-way arbiter for the single register-bank write port with a registered write command.
// Define RR_ARB_EN for round-robin priority; otherwise fixed priority 0 > 1 > 2.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 2
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wr_arbiter_if.slave bus
);

  logic [NREQ-1:0] elig_s;
  logic [NREQ-1:0] win_oh_s;
  logic [2:0]      pick_s;
  logic            win_vld_s;
  logic [1:0]      win_idx_s;
  logic [AW-1:0]   win_dr_s;
  logic [DW-1:0]   win_data_s;

  logic [NREQ-1:0] gnt_r;
  logic            write_r;
  logic [AW-1:0]   dr_r;
  logic [DW-1:0]   wr_data_r;

  // Returns {valid, index} of the first eligible requester in search order a, b, c.
  function automatic logic [2:0] pick3(input logic [2:0] e, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] c);
    logic [2:0] r;
    r = 3'b000;
    if (e[a]) begin
      r = {1'b1, a};
    end else if (e[b]) begin
      r = {1'b1, b};
    end else if (e[c]) begin
      r = {1'b1, c};
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // The requester currently holding gnt still has req high, so mask it out.
  assign elig_s = bus.req & ~gnt_r;

`ifdef RR_ARB_EN
  logic [1:0] last_r;

  // Round-robin search starts just after the most recent grant.
  always_comb begin
    pick_s = 3'b000;
    case (last_r)
      2'd0:    pick_s = pick3(elig_s, 2'd1, 2'd2, 2'd0);
      2'd1:    pick_s = pick3(elig_s, 2'd2, 2'd0, 2'd1);
      default: pick_s = pick3(elig_s, 2'd0, 2'd1, 2'd2);
    endcase
  end

  // Pointer to the last granted requester; moves only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 2'd2;
    end else if (win_vld_s) begin
      last_r <= win_idx_s;
    end else begin
      last_r <= last_r;
    end
  end
`else
  // Fixed priority search: 0 first, 2 last.
  always_comb begin
    pick_s = pick3(elig_s, 2'd0, 2'd1, 2'd2);
  end
`endif

  assign win_vld_s = pick_s[2];
  assign win_idx_s = pick_s[1:0];

  // Winner one-hot and its write command selected from the packed request buses.
  always_comb begin
    win_oh_s   = 3'b000;
    win_dr_s   = {AW{1'b0}};
    win_data_s = {DW{1'b0}};
    case (win_idx_s)
      2'd0: begin
        win_oh_s   = 3'b001;
        win_dr_s   = bus.reqDr[0*AW +: AW];
        win_data_s = bus.reqData[0*DW +: DW];
      end
      2'd1: begin
        win_oh_s   = 3'b010;
        win_dr_s   = bus.reqDr[1*AW +: AW];
        win_data_s = bus.reqData[1*DW +: DW];
      end
      2'd2: begin
        win_oh_s   = 3'b100;
        win_dr_s   = bus.reqDr[2*AW +: AW];
        win_data_s = bus.reqData[2*DW +: DW];
      end
      default: begin
        win_oh_s   = 3'b000;
        win_dr_s   = {AW{1'b0}};
        win_data_s = {DW{1'b0}};
      end
    endcase
    if (!win_vld_s) begin
      win_oh_s = 3'b000;
    end else begin
      win_oh_s = win_oh_s;
    end
  end

  // Registered grant and bank write command; dr/wrData hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r     <= 3'b000;
      write_r   <= 1'b0;
      dr_r      <= {AW{1'b0}};
      wr_data_r <= {DW{1'b0}};
    end else if (win_vld_s) begin
      gnt_r     <= win_oh_s;
      write_r   <= 1'b1;
      dr_r      <= win_dr_s;
      wr_data_r <= win_data_s;
    end else begin
      gnt_r     <= 3'b000;
      write_r   <= 1'b0;
      dr_r      <= dr_r;
      wr_data_r <= wr_data_r;
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.write  = write_r;
  assign bus.dr     = dr_r;
  assign bus.wrData = wr_data_r;
  assign bus.busy   = |(elig_s & ~win_oh_s);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed table-driven bench for regfile_wr_arbiter with a 4x32 bank model on
// the write port; expectations follow RR_ARB_EN when it is defined.
module tb_regfile_wr_arbiter;

  localparam logic [31:0] D0 = 32'hDEAD_BEEF;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'h2222_2222;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        exp_busy;
    logic [2:0]  exp_gnt;
    logic        exp_write;
    logic [1:0]  exp_dr;
    logic [31:0] exp_wd;
  } vec_t;

  logic clk;
  logic rst;
  logic [31:0] bank [4];
  vec_t vec [18];
  int n_cmp;
  int n_err;
  logic [2:0] exp_g;
  bit seen2;

  regfile_wr_arbiter_if #(.NREQ(3), .DW(32), .AW(2)) bus ();

  regfile_wr_arbiter #(.NREQ(3), .DW(32), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.write) bank[bus.dr] <= bus.wrData;
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    seen2 = 1'b0;
    rst = 1'b1;
    bus.req = 3'b000;
    bus.reqDr = {2'd1, 2'd3, 2'd2};
    bus.reqData = {D2, D1, D0};

    //           rst   req     busy  gnt     wr    dr    wrData
    vec[0]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 32'h0};
    vec[1]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 32'h0};
    vec[2]  = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 32'h0};
    vec[3]  = '{1'b0, 3'b001, 1'b0, 3'b001, 1'b1, 2'd2, D0};
    vec[4]  = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd2, D0};
    vec[5]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 32'h0};
    vec[6]  = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd2, D0};
    vec[7]  = '{1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd3, D1};
    vec[8]  = '{1'b0, 3'b110, 1'b0, 3'b100, 1'b1, 2'd1, D2};
    vec[9]  = '{1'b0, 3'b100, 1'b0, 3'b000, 1'b0, 2'd1, D2};
    vec[10] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd1, D2};
    vec[11] = '{1'b0, 3'b010, 1'b0, 3'b010, 1'b1, 2'd3, D1};
    vec[12] = '{1'b1, 3'b010, 1'b0, 3'b000, 1'b0, 2'd0, 32'h0};
    vec[13] = '{1'b0, 3'b010, 1'b0, 3'b010, 1'b1, 2'd3, D1};
    vec[14] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd3, D1};
`ifdef RR_ARB_EN
    vec[15] = '{1'b0, 3'b110, 1'b1, 3'b100, 1'b1, 2'd1, D2};
    vec[16] = '{1'b0, 3'b110, 1'b0, 3'b010, 1'b1, 2'd3, D1};
    vec[17] = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 2'd3, D1};
`else
    vec[15] = '{1'b0, 3'b110, 1'b1, 3'b010, 1'b1, 2'd3, D1};
    vec[16] = '{1'b0, 3'b110, 1'b0, 3'b100, 1'b1, 2'd1, D2};
    vec[17] = '{1'b0, 3'b100, 1'b0, 3'b000, 1'b0, 2'd1, D2};
`endif

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = vec[i].rst;
      bus.req = vec[i].req;
      #1;
      chk("busy", i, {31'b0, bus.busy}, {31'b0, vec[i].exp_busy});
      @(posedge clk);
      #1;
      chk("gnt", i, {29'b0, bus.gnt}, {29'b0, vec[i].exp_gnt});
      chk("write", i, {31'b0, bus.write}, {31'b0, vec[i].exp_write});
      chk("dr", i, {30'b0, bus.dr}, {30'b0, vec[i].exp_dr});
      chk("wrData", i, bus.wrData, vec[i].exp_wd);
      if (i == 4) chk("bank_sr1", 2, bank[2], D0);
    end

    // Persistent requesters: 0 and 1 re-request at once, 2 holds throughout.
    @(negedge clk);
    rst = 1'b1;
    bus.req = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    bus.req = 3'b111;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
`ifdef RR_ARB_EN
      exp_g = 3'b001 << (i % 3);
`else
      exp_g = (i % 2 == 0) ? 3'b001 : 3'b010;
`endif
      chk("starve_gnt", i, {29'b0, bus.gnt}, {29'b0, exp_g});
      chk("starve_write", i, {31'b0, bus.write}, 32'd1);
      if (i < 3 && bus.gnt[2]) seen2 = 1'b1;
    end
`ifdef RR_ARB_EN
    chk("rr_req2_within3", 0, {31'b0, seen2}, 32'd1);
`endif
    @(negedge clk);
    bus.req = 3'b000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("idle_write", 0, {31'b0, bus.write}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single write port of the 4x32 register bank (2-bit `dr`, 32-bit `wrData`, `write` strobe) among three producers, e.g. ALU, load unit and move/immediate unit. Each producer issues a request and holds it until granted. The arbiter picks one winner per cycle and drives a registered write command straight into the bank's write port. Read ports (`sr1`, `sr2`, `rdData1`, `rdData2`) are untouched and connect to the bank directly.

## Interface
Parameters:
- `NREQ`, 3: number of requesters. Fixed at 3; other values are unsupported.
- `DW`, 32: data width. Matches the bank's `wrData`.
- `AW`, 2: register address width. Matches the bank's `dr`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  3  per-requester request; bit k belongs to requester k.
- `reqDr`  in  3*AW  destination register per requester; requester k uses bits [k*AW +: AW].
- `reqData`  in  3*DW  write data per requester; requester k uses bits [k*DW +: DW].
- `gnt`  out  3  one-hot grant pulse, registered.
- `write`  out  1  write strobe to the bank, registered.
- `dr`  out  AW  destination register to the bank, registered.
- `wrData`  out  DW  write data to the bank, registered.
- `busy`  out  1  high when any `req` bit is still eligible and was not granted this cycle.

## Operation
- Eligible set:
  - `elig = req & ~gnt`.
  - A requester granted in the current cycle is masked. Its `req` is still high while it observes `gnt`.
- Winner selection is combinational over `elig`; all outputs are updated at the next posedge.
  - If `elig != 0`, the selected winner k sets `gnt <= onehot(k)`, `write <= 1`, `dr <= reqDr[k]`, `wrData <= reqData[k]`.
  - If `elig == 0`, `gnt <= 0` and `write <= 0`. `dr` and `wrData` hold their previous values.
- Requester contract:
  - Hold `req`, `reqDr` and `reqData` stable from assertion until the cycle in which `gnt[k]` is high.
  - After that cycle, either drop `req` or present the next request. Changing the held values earlier is illegal and unchecked.
- Priority, with `RR_ARB_EN` undefined: fixed order, 0 > 1 > 2.
- Priority, with `RR_ARB_EN` defined: round-robin, described under Configuration.
- `busy = |(elig & ~winnerOneHot)`.
  - Combinational.
  - Means at least one eligible requester is still waiting after this cycle's selection.
- No queueing: pending requests live only in the requesters' held `req` lines.
- Duplicate destination registers from different requesters are legal. They are written in grant order, so the last grant wins.

## Timing
- Reset (`rst` high at posedge):
  - `gnt = 0`, `write = 0`, `dr = 0`, `wrData = 0`, round-robin pointer `last = 2`.
  - `req` is ignored in that cycle.
- Latency: `req[k]` is sampled at edge N; `gnt[k]`, `write`, `dr` and `wrData` are valid during cycle N+1. The bank captures the data at edge N+2.
- Throughput:
  - Up to one write per cycle when different requesters alternate.
  - A single requester that re-requests back-to-back gets a grant every second cycle, because of the mask.
- Simultaneous requests: exactly one grant per cycle; `gnt` is always one-hot or zero.
- Reset mid-operation:
  - The pending grant and write are dropped; `write` is 0 in the cycle after reset.
  - Requesters keep `req` high and are re-arbitrated from the reset priority.
- `busy` reflects the current cycle's inputs and state only.

## Configuration
- `RR_ARB_EN` defined:
  - A 2-bit pointer `last` records the index of the most recent grant.
  - Search order is `last+1`, `last+2`, `last` (mod 3).
  - `last` updates only on a grant.
  - Worst-case wait with all three requesting is 2 grants.
- `RR_ARB_EN` undefined:
  - Fixed priority 0 > 1 > 2.
  - No `last` register is instantiated.
  - Requester 2 can starve.

## Test plan
- Reset, then idle: `rst` high for 2 cycles, `req=000` → `gnt=000`, `write=0`, `dr=0`, `wrData=0` throughout.
- Single request: after reset, `req=001` with `reqDr[1:0]=2` and data `0xDEADBEEF`, dropped after `gnt` → next cycle `gnt=001`, `write=1`, `dr=2`, `wrData=0xDEADBEEF`; one cycle later `write=0`. A bank read of `sr1=2` afterwards returns `0xDEADBEEF`.
- Three-way contention, `RR_ARB_EN` defined: `req=111` held, each requester dropping after its grant → grants 0, 1, 2 on three consecutive cycles; `busy=1` for the first two cycles.
- Three-way contention, `RR_ARB_EN` undefined: the same stimulus → grants 0, 1, 2.
- Starvation and masking: requesters 0 and 1 re-request immediately after every grant, requester 2 holds → in fixed mode `gnt` alternates 001 and 010 and never reaches 2; in round-robin mode requester 2 is granted within 3 cycles.
- Reset mid-grant: `req=010` at edge N, `rst=1` at edge N+1 → `write=0` in cycle N+2; with `req` still high, `gnt=010` in the first cycle after `rst` is released.
